// File: rtl/addr_pkg.sv
// addr_pkg: mode codes and default operand width shared by the addr_pipe slice
package addr_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/addr_sat_alu.sv
// addr_sat_alu: add/sub/accumulate/load with carry-borrow detection and optional clamping
module addr_sat_alu import addr_pkg::*; #(
  parameter int WIDTH = ADDR_WIDTH,
  parameter bit SAT   = 1'b0
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_x, w_y;
  logic [WIDTH:0]   w_sum, w_dif;
  // ACC reuses the adder with the accumulator in place of operand A
  assign w_x   = i_mode == MODE_ACC ? i_acc : i_a;
  assign w_y   = i_mode == MODE_ACC ? i_a : i_b;
  assign w_sum = {1'b0, w_x} + {1'b0, w_y};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};
  assign o_ovf = i_mode == MODE_LOAD ? 1'b0 : i_mode == MODE_SUB ? w_dif[WIDTH] : w_sum[WIDTH];
  assign o_res = i_mode == MODE_LOAD ? i_a :
                 i_mode == MODE_SUB  ? (SAT && w_dif[WIDTH] ? '0 : w_dif[WIDTH-1:0]) :
                                       (SAT && w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0]);
endmodule

// File: rtl/addr_pipe.sv
// addr_pipe: two-stage valid/ready arithmetic pipeline with an in-order accumulator
module addr_pipe import addr_pkg::*; #(
  parameter int WIDTH = ADDR_WIDTH,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);
  logic             r_s1_valid, r_out_valid, r_ovf, w_ovf, w_adv;
  logic [1:0]       r_s1_mode;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_acc, r_c, w_res;
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign ovf       = r_ovf;
  addr_sat_alu #(.WIDTH(WIDTH), .SAT(SAT)) u_alu (
    .i_mode(r_s1_mode),
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_acc (r_acc),
    .o_res (w_res),
    .o_ovf (w_ovf)
  );
  // acc is written as S1 drains, so the next op in S1 always sees the prior write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_ADD;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_mode   <= mode;
      r_s1_a      <= a;
      r_s1_b      <= b;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c   <= w_res;
        r_ovf <= w_ovf;
        if (r_s1_mode[1]) r_acc <= w_res;
      end
    end
  end
endmodule

// File: tb/tb_addr_pipe.sv
// tb_addr_pipe: drives wrap and saturating instances together against a transaction-order model
module tb_addr_pipe;
  localparam int W = 8;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [1:0] mode = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [W-1:0] c0, c1;
  int n_checks = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  logic [W:0] log0[$], log1[$];
  int logc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addr_pipe #(.WIDTH(W), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .ovf(ovf0));
  addr_pipe #(.WIDTH(W), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .c(c1), .ovf(ovf1));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Results are computed in acceptance order from the mode rules; returns {new acc, c, ovf}
  function automatic logic [2*W:0] op(input logic [1:0] m, input int x, input int y, input int acc, input bit sat);
    int lim, r, nacc;
    bit o;
    lim = 2 ** W;
    nacc = acc;
    o = 0;
    if (m == 2'd0) begin
      r = x + y; o = r >= lim; if (o) r = sat ? lim - 1 : r - lim;
    end else if (m == 2'd1) begin
      r = x - y; o = y > x; if (o) r = sat ? 0 : r + lim;
    end else if (m == 2'd2) begin
      r = acc + x; o = r >= lim; if (o) r = sat ? lim - 1 : r - lim; nacc = r;
    end else begin
      r = x; nacc = x;
    end
    return {nacc[W-1:0], r[W-1:0], o};
  endfunction

  typedef struct packed {logic v; logic [W-1:0] c0; logic [W-1:0] c1; logic o0; logic o1;} slot_t;
  slot_t m_s1, m_s2;
  logic [W-1:0] m_acc0, m_acc1;
  logic [2*W:0] r0, r1;
  wire m_adv = !m_s2.v || out_ready;

  always_comb begin
    r0 = op(mode, a, b, m_acc0, 1'b0);
    r1 = op(mode, a, b, m_acc1, 1'b1);
  end

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_acc0 <= '0; m_acc1 <= '0;
    end else if (m_adv) begin
      m_s2 <= m_s1;
      m_s1 <= in_valid ? {1'b1, r0[W:1], r1[W:1], r0[0], r1[0]} : '0;
      if (in_valid) begin
        m_acc0 <= r0[2*W:W+1];
        m_acc1 <= r1[2*W:W+1];
      end
    end

  always @(negedge clk) begin
    chk("in_ready0", in_ready0, m_adv);
    chk("in_ready1", in_ready1, m_adv);
    chk("out_valid0", out_valid0, m_s2.v);
    chk("out_valid1", out_valid1, m_s2.v);
    if (m_s2.v) begin
      chk("c0", c0, m_s2.c0);
      chk("ovf0", ovf0, m_s2.o0);
      chk("c1", c1, m_s2.c1);
      chk("ovf1", ovf1, m_s2.o1);
    end
    if (out_valid0 && out_ready) begin
      log0.push_back({ovf0, c0});
      logc.push_back(cyc);
    end
    if (out_valid1 && out_ready) log1.push_back({ovf1, c1});
  end

  task automatic drive(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 0;
    in_valid = 1; mode = m; a = x; b = y;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready0) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin acc_cyc = cyc; @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] e_c0[13] = '{11, 44, 252, 4, 10, 15, 22, 16, 3, 7, 7, 16, 3};
  logic [W-1:0] e_c1[13] = '{11, 255, 0, 4, 10, 15, 22, 255, 3, 7, 7, 255, 3};
  logic         e_o[13]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    int t0, rel;
    #1 reset = 0;
    in_valid = 1; mode = 2'd0; a = 4; b = 7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    @(posedge clk); #1;
    reset = 1;
    rel = cyc;
    drive(2'd0, 4, 7);
    t0 = acc_cyc;
    chk("first_accept", acc_cyc, rel);
    drive(2'd0, 200, 100);
    drive(2'd1, 5, 9);
    drive(2'd1, 9, 5);
    drive(2'd3, 10, 0);
    drive(2'd2, 5, 0);
    drive(2'd2, 7, 0);
    drive(2'd2, 250, 0);
    idle(4);
    out_ready = 0;
    drive(2'd0, 1, 2);
    drive(2'd0, 3, 4);
    in_valid = 1; mode = 2'd1; a = 10; b = 3;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready0, 0);
      chk("stall_valid", out_valid0, 1);
      chk("stall_c", c0, 3);
      @(posedge clk); #1;
    end
    out_ready = 1;
    drive(2'd1, 10, 3);
    drive(2'd2, 0, 0);
    idle(4);
    drive(2'd3, 100, 0);
    drive(2'd2, 1, 0);
    chk("pre_rst_valid", out_valid0, 1);
    #1 reset = 0;
    #1;
    chk("mid_rst_valid0", out_valid0, 0);
    chk("mid_rst_valid1", out_valid1, 0);
    chk("mid_rst_c0", c0, 0);
    chk("mid_rst_ovf0", ovf0, 0);
    chk("mid_rst_in_ready", in_ready0, 1);
    in_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    drive(2'd2, 3, 0);
    idle(4);
    chk("log_count0", log0.size(), 13);
    chk("log_count1", log1.size(), 13);
    if (log0.size() >= 13 && log1.size() >= 13) begin
      for (int i = 0; i < 13; i++) begin
        chk($sformatf("pin_c0_%0d", i), log0[i][W-1:0], e_c0[i]);
        chk($sformatf("pin_ovf0_%0d", i), log0[i][W], e_o[i]);
        chk($sformatf("pin_c1_%0d", i), log1[i][W-1:0], e_c1[i]);
        chk($sformatf("pin_ovf1_%0d", i), log1[i][W], e_o[i]);
      end
      chk("latency", logc[0] - t0, 2);
      for (int i = 5; i < 8; i++) chk($sformatf("acc_b2b_%0d", i), logc[i] - logc[i-1], 1);
    end
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    out_ready = 1;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
